parallel_hypervisor_cpu_ocimem_ctrl: RTL and testbench
======================================================

# parallel_hypervisor_cpu_ocimem_ctrl

Debug on-chip memory (OCI RAM) controller for the hypervisor Nios II core. It sits directly downstream of the debug slave sysclk stage. It consumes the `jdo` command word and the `take_action_ocimem_*` pulses, and services JTAG reads and writes to a private monitor RAM. It arbitrates those accesses against CPU debug-mode accesses and drives `MonDReg`, `monitor_ready`, `monitor_error` and `monitor_go` back to the debug slave and the CPU.

## Interface

Parameters:
- `ADDR_W`, default 8: RAM word-address width (2^ADDR_W × 32-bit words). Legal range 4..16.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `jdo`  in  38  JTAG command word. Stable whenever a take pulse is high.
- `take_action_ocimem_a`  in  1  address-load / monitor-control pulse.
- `take_no_action_ocimem_a`  in  1  read-next pulse.
- `take_action_ocimem_b`  in  1  write-next pulse.
- `cpu_address`  in  ADDR_W+1  word address. The MSB selects the control register.
- `cpu_read`, `cpu_write`  in  1  CPU access strobes (Avalon-MM).
- `cpu_writedata`  in  32  CPU write data.
- `cpu_readdata`  out  32  CPU read data. Valid when `cpu_read` is high and `cpu_waitrequest` is low.
- `cpu_waitrequest`  out  1  stall signal to the CPU.
- `MonDReg`  out  32  JTAG read-back data register.
- `monitor_ready`, `monitor_error`, `monitor_go`  out  1  debug monitor handshake flags.

## Operation

jdo field meanings on `take_action_ocimem_a`:
- `jdo[17 +: ADDR_W]` is loaded into `MonAReg`.
- `jdo[34]`: read at the new address.
- `jdo[35]`: clear `monitor_ready` and `monitor_error`.
- `jdo[36]`: set `monitor_go`.

JTAG commands:
- `take_no_action_ocimem_a` reads the RAM at `MonAReg`, then increments `MonAReg`.
- `take_action_ocimem_b` writes `jdo[34:3]` to `MonAReg`, then increments `MonAReg`.
- `MonAReg` wraps from 2^ADDR_W−1 to 0.

JTAG FSM:
- States: IDLE, ACCESS, CAPTURE.
- IDLE → ACCESS on any qualifying pulse. For ocimem_a with `jdo[34]`=0, no RAM access occurs: the fields are applied and the FSM stays in IDLE.
- ACCESS drives the RAM port. Reads go to CAPTURE; writes return to IDLE.
- CAPTURE loads `MonDReg` from the RAM output, then returns to IDLE.
- Pulses arriving outside IDLE are ignored. TCK-paced pulses are far apart in normal use.
- Simultaneous pulses use fixed priority: ocimem_a, then ocimem_b, then no_action_a.

CPU port:
- RAM read (MSB=0): two cycles. `cpu_waitrequest`=1 in the first cycle, then 0 with data in the second.
- RAM write: zero-wait.
- Control register (MSB=1, any low bits): zero-wait.
  - Read returns `{29'b0, monitor_go, monitor_error, monitor_ready}`.
  - Write bit0=1 sets `monitor_ready`.
  - Write bit1=1 sets `monitor_error`.
  - Write bit2=1 clears `monitor_go`.
  - Zero bits in the write have no effect on the flags.

Arbitration:
- JTAG always wins the RAM.
- While the FSM is in ACCESS, any CPU RAM access sees `cpu_waitrequest`=1 and is retried by the CPU.
- A CPU RAM read already in its second cycle completes unaffected, because the RAM output is registered.
- If a JTAG `jdo[35]` clear and a CPU flag-set write land in the same cycle, the set wins.

Reset values:
- `MonAReg`=0, `MonDReg`=0.
- All flags=0.
- FSM=IDLE, CPU read phase cleared.
- `cpu_waitrequest`=0, `cpu_readdata`=0.
- RAM contents are not reset.
- Reset asserted mid-access aborts the access. A write in ACCESS at the reset edge may or may not land; the bench treats that word as undefined.

## Timing

- JTAG read: pulse at cycle N, ACCESS at N+1, `MonDReg` valid from N+3.
- JTAG write: pulse at N, RAM updated at the end of N+1, `MonAReg` incremented at N+2.
- Flag updates from ocimem_a or a CPU control-register write are visible the cycle after the event.
- CPU RAM read latency is 2 cycles uncontended, plus 1 per JTAG ACCESS cycle collided with.

## Configuration

Macro `PARALLEL_HYPERVISOR_OCIMEM_WRITE_PROTECT_EN`:
- Defined: CPU RAM writes while `monitor_go`=0 are silently dropped (zero-wait, no RAM update). Control-register writes are unaffected.
- Undefined: CPU RAM writes always land.

## Structure

- Package `parallel_hypervisor_cpu_ocimem_pkg`:
  - jdo bit-offset constants: `JDO_ADDR_LSB`=17, `JDO_RD`=34, `JDO_CLR`=35, `JDO_GO`=36, `JDO_WDATA_LSB`=3.
  - Control-register bit constants.
  - FSM state enum.
- Sub-module `parallel_hypervisor_cpu_ocimem_ram`: single-port synchronous 2^ADDR_W×32 RAM, one-cycle registered read, write-enable input.

## Test plan

- ocimem_a with addr=0x10 and `jdo[34]`=0, then three ocimem_b writes of 0xA5A5_0001..3 → RAM[0x10..0x12] hold those values; `MonAReg`=0x13.
- ocimem_a with addr=0x10 and `jdo[34]`=1, then two no_action_a pulses → `MonDReg` = 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003 in turn, each valid at pulse+3.
- `MonAReg`=2^ADDR_W−1, then an ocimem_b write → `MonAReg` wraps to 0.
- ocimem_a with `jdo[36]`=1 → `monitor_go`=1. CPU writes 0x5 to the control register → `monitor_ready`=1, `monitor_go`=0. CPU reads the control register → 0x1.
- CPU RAM read issued in the same cycle JTAG enters ACCESS → `cpu_waitrequest` held 2 cycles, correct data returned.
- With the macro defined and `monitor_go`=0, CPU writes 0xDEAD to addr 0 → RAM[0] unchanged. After `monitor_go` is set, the same write lands.

Source files
------------

// File: rtl/parallel_hypervisor_cpu_ocimem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parallel_hypervisor_cpu_ocimem_pkg
// Description : Shared constants and FSM encoding for the OCI RAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package parallel_hypervisor_cpu_ocimem_pkg;

    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RD        = 34;
    localparam int JDO_CLR       = 35;
    localparam int JDO_GO        = 36;
    localparam int JDO_WDATA_LSB = 3;

    localparam int CTRL_READY_BIT  = 0;
    localparam int CTRL_ERROR_BIT  = 1;
    localparam int CTRL_GO_CLR_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } ocimem_state_e;

endpackage
`default_nettype wire

// File: rtl/parallel_hypervisor_cpu_ocimem_ram.sv
`default_nettype none
// ============================================================================
// Module      : parallel_hypervisor_cpu_ocimem_ram
// Description : Single-port synchronous 2^ADDR_W x 32 RAM, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_hypervisor_cpu_ocimem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    // Contents are deliberately not reset; read-during-write returns old data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/parallel_hypervisor_cpu_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parallel_hypervisor_cpu_ocimem_ctrl
// Description : Debug OCI RAM controller; JTAG accesses win over CPU accesses.
//               Optional PARALLEL_HYPERVISOR_OCIMEM_WRITE_PROTECT_EN drops CPU
//               RAM writes while monitor_go is low.
// Revision    : 1.0 - initial release
// ============================================================================
module parallel_hypervisor_cpu_ocimem_ctrl
    import parallel_hypervisor_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W:0]   cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic              monitor_go
);

    ocimem_state_e     r_state;
    logic [ADDR_W-1:0] r_mon_addr;
    logic              r_jtag_wr;
    logic [31:0]       r_wdata;
    logic              r_rd_phase;

    logic              w_idle;
    logic              w_jtag_access;
    logic              w_take_a;
    logic              w_take_b;
    logic              w_take_n;
    logic              w_ctrl_sel;
    logic              w_ctrl_wr;
    logic              w_ram_rd_req;
    logic              w_ram_wr_req;
    logic              w_cpu_rd_start;
    logic              w_wr_allow;
    logic              w_cpu_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_ram_q;
    logic              w_unused;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_jtag_access = (r_state == ST_ACCESS);

    // Fixed priority among simultaneous pulses: a, then b, then no_action_a.
    assign w_take_a = w_idle & take_action_ocimem_a;
    assign w_take_b = w_idle & ~take_action_ocimem_a & take_action_ocimem_b;
    assign w_take_n = w_idle & ~take_action_ocimem_a & ~take_action_ocimem_b
                    & take_no_action_ocimem_a;

    assign w_ctrl_sel     = cpu_address[ADDR_W];
    assign w_ctrl_wr      = cpu_write & w_ctrl_sel;
    assign w_ram_rd_req   = cpu_read & ~w_ctrl_sel;
    assign w_ram_wr_req   = cpu_write & ~w_ctrl_sel;
    assign w_cpu_rd_start = w_ram_rd_req & ~r_rd_phase & ~w_jtag_access;

`ifdef PARALLEL_HYPERVISOR_OCIMEM_WRITE_PROTECT_EN
    assign w_wr_allow = monitor_go;
`else
    assign w_wr_allow = 1'b1;
`endif

    assign w_cpu_we = w_ram_wr_req & ~w_jtag_access & w_wr_allow;

    assign w_ram_addr  = w_jtag_access ? r_mon_addr : cpu_address[ADDR_W-1:0];
    assign w_ram_we    = w_jtag_access ? r_jtag_wr  : w_cpu_we;
    assign w_ram_wdata = w_jtag_access ? r_wdata    : cpu_writedata;

    // A read already in its second cycle is served from the registered RAM
    // output, so a JTAG access in that cycle cannot disturb it.
    assign cpu_waitrequest = (w_ram_rd_req & ~r_rd_phase) | (w_ram_wr_req & w_jtag_access);
    assign cpu_readdata    = r_rd_phase ? w_ram_q :
                             (cpu_read & w_ctrl_sel) ? {29'b0, monitor_go, monitor_error, monitor_ready} :
                             32'b0;

    assign w_unused = ^{jdo[37], jdo[2:0]};

    parallel_hypervisor_cpu_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_mon_addr <= '0;
            r_jtag_wr  <= 1'b0;
            r_wdata    <= '0;
            MonDReg    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_a) begin
                        r_mon_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                        r_jtag_wr  <= 1'b0;
                        if (jdo[JDO_RD]) begin
                            r_state <= ST_ACCESS;
                        end
                    end else if (w_take_b) begin
                        r_jtag_wr <= 1'b1;
                        r_wdata   <= jdo[JDO_WDATA_LSB +: 32];
                        r_state   <= ST_ACCESS;
                    end else if (w_take_n) begin
                        r_jtag_wr <= 1'b0;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_mon_addr <= r_mon_addr + ADDR_W'(1);
                    r_state    <= r_jtag_wr ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    MonDReg <= w_ram_q;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_phase <= 1'b0;
        end else begin
            r_rd_phase <= w_cpu_rd_start;
        end
    end

    // CPU sets of ready/error override a same-cycle JTAG clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            monitor_go    <= 1'b0;
        end else begin
            if (w_ctrl_wr && cpu_writedata[CTRL_READY_BIT]) begin
                monitor_ready <= 1'b1;
            end else if (w_take_a && jdo[JDO_CLR]) begin
                monitor_ready <= 1'b0;
            end
            if (w_ctrl_wr && cpu_writedata[CTRL_ERROR_BIT]) begin
                monitor_error <= 1'b1;
            end else if (w_take_a && jdo[JDO_CLR]) begin
                monitor_error <= 1'b0;
            end
            if (w_take_a && jdo[JDO_GO]) begin
                monitor_go <= 1'b1;
            end else if (w_ctrl_wr && cpu_writedata[CTRL_GO_CLR_BIT]) begin
                monitor_go <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parallel_hypervisor_cpu_ocimem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_parallel_hypervisor_cpu_ocimem_ctrl
// Description : Self-checking bench with a transaction-timed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parallel_hypervisor_cpu_ocimem_ctrl;
    import parallel_hypervisor_cpu_ocimem_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [37:0]       jdo = '0;
    logic              take_action_ocimem_a = 1'b0;
    logic              take_no_action_ocimem_a = 1'b0;
    logic              take_action_ocimem_b = 1'b0;
    logic [ADDR_W:0]   cpu_address = '0;
    logic              cpu_read = 1'b0;
    logic              cpu_write = 1'b0;
    logic [31:0]       cpu_writedata = '0;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              monitor_go;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    parallel_hypervisor_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .monitor_go              (monitor_go)
    );

    // ---------------- reference model (event-timed) ----------------
    logic [31:0]       m_mem [DEPTH];
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_dreg = '0;
    logic              m_ready = 1'b0, m_error = 1'b0, m_go = 1'b0;
    int                cyc = 0;
    bit                jt_busy = 1'b0, jt_wr = 1'b0;
    int                jt_acc = 0;
    logic [31:0]       jt_wdata = '0, jt_cap = '0;
    bit                m_granted = 1'b0;
    int                m_gcyc = 0;
    logic [31:0]       m_gdata = '0;

    bit                mv_idle, mv_acc, mv_wp_ok, mv_ctrl_wr, mv_ram_wr, mv_ram_rd;

    // A JTAG op accepted in cycle N uses the RAM in N+1; a read also needs N+2.
    function automatic bit jt_idle_at(int c);
        return !jt_busy || c > (jt_wr ? jt_acc : jt_acc + 1);
    endfunction

    function automatic bit acc_at(int c);
        return jt_busy && c == jt_acc;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_addr = '0; m_dreg = '0;
            m_ready = 1'b0; m_error = 1'b0; m_go = 1'b0;
            jt_busy = 1'b0; m_granted = 1'b0;
        end else begin
            mv_idle    = jt_idle_at(cyc);
            mv_acc     = acc_at(cyc);
`ifdef PARALLEL_HYPERVISOR_OCIMEM_WRITE_PROTECT_EN
            mv_wp_ok   = m_go;
`else
            mv_wp_ok   = 1'b1;
`endif
            mv_ctrl_wr = cpu_write && cpu_address[ADDR_W];
            mv_ram_wr  = cpu_write && !cpu_address[ADDR_W];
            mv_ram_rd  = cpu_read && !cpu_address[ADDR_W];

            if (mv_acc) begin
                if (jt_wr) m_mem[m_addr] = jt_wdata;
                else       jt_cap = m_mem[m_addr];
                m_addr = m_addr + 1'b1;
            end
            if (jt_busy && !jt_wr && cyc == jt_acc + 1) m_dreg = jt_cap;

            if (m_granted && cyc == m_gcyc + 1) begin
                m_granted = 1'b0;
            end else if (mv_ram_rd && !m_granted && !mv_acc) begin
                m_granted = 1'b1;
                m_gcyc    = cyc;
                m_gdata   = m_mem[cpu_address[ADDR_W-1:0]];
            end
            if (mv_ram_wr && !mv_acc && mv_wp_ok) m_mem[cpu_address[ADDR_W-1:0]] = cpu_writedata;

            if (mv_idle && take_action_ocimem_a) begin
                m_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_CLR]) begin m_ready = 1'b0; m_error = 1'b0; end
                if (jdo[JDO_RD]) begin jt_busy = 1'b1; jt_wr = 1'b0; jt_acc = cyc + 1; end
            end else if (mv_idle && take_action_ocimem_b) begin
                jt_busy = 1'b1; jt_wr = 1'b1; jt_acc = cyc + 1; jt_wdata = jdo[34:3];
            end else if (mv_idle && take_no_action_ocimem_a) begin
                jt_busy = 1'b1; jt_wr = 1'b0; jt_acc = cyc + 1;
            end

            if (mv_ctrl_wr) begin
                if (cpu_writedata[0]) m_ready = 1'b1;
                if (cpu_writedata[1]) m_error = 1'b1;
                if (cpu_writedata[2]) m_go    = 1'b0;
            end
            if (mv_idle && take_action_ocimem_a && jdo[JDO_GO]) m_go = 1'b1;
        end
        cyc++;
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic cmp_exp_w;
    always @(negedge clk) begin
        if (reset_n) begin
            chk("MonDReg", MonDReg, m_dreg);
            chk("flags", {29'b0, monitor_go, monitor_error, monitor_ready},
                         {29'b0, m_go, m_error, m_ready});
            if (cpu_read && cpu_address[ADDR_W]) begin
                chk("ctrl_rd_wait", 32'(cpu_waitrequest), 32'd0);
                chk("ctrl_rd_data", cpu_readdata, {29'b0, m_go, m_error, m_ready});
            end else if (cpu_read) begin
                cmp_exp_w = !(m_granted && cyc == m_gcyc + 1);
                chk("ram_rd_wait", 32'(cpu_waitrequest), 32'(cmp_exp_w));
                if (!cmp_exp_w && !$isunknown(m_gdata)) chk("ram_rd_data", cpu_readdata, m_gdata);
            end
            if (cpu_write) chk("wr_wait", 32'(cpu_waitrequest), 32'(!cpu_address[ADDR_W] && acc_at(cyc)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    function automatic logic [37:0] mk_a(logic [ADDR_W-1:0] a, logic rd, logic clr, logic go);
        logic [37:0] j;
        j = '0;
        j[JDO_ADDR_LSB +: ADDR_W] = a;
        j[JDO_RD] = rd; j[JDO_CLR] = clr; j[JDO_GO] = go;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a
    task automatic jtag(int kind, logic [37:0] j);
        step();
        jdo = j;
        case (kind)
            0:       take_action_ocimem_a = 1'b1;
            1:       take_action_ocimem_b = 1'b1;
            default: take_no_action_ocimem_a = 1'b1;
        endcase
    endtask

    task automatic cpu_wr(logic [ADDR_W:0] a, logic [31:0] d);
        int n;
        n = 0;
        step(); cpu_address = a; cpu_writedata = d; cpu_write = 1'b1;
        @(negedge clk);
        while (cpu_waitrequest && n < 10) begin
            n++;
            step(); cpu_address = a; cpu_writedata = d; cpu_write = 1'b1;
            @(negedge clk);
        end
        if (cpu_waitrequest) begin
            tests++; fails++;
            $display("FAIL cpu_wr_timeout: waitrequest still 1, required 0 within 10 cycles");
        end
    endtask

    task automatic cpu_rd(logic [ADDR_W:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        step(); cpu_address = a; cpu_read = 1'b1;
        @(negedge clk);
        while (cpu_waitrequest && waits < 10) begin
            waits++;
            step(); cpu_address = a; cpu_read = 1'b1;
            @(negedge clk);
        end
        d = cpu_readdata;
        if (cpu_waitrequest) begin
            tests++; fails++;
            $display("FAIL cpu_rd_timeout: waitrequest still 1, required 0 within 10 cycles");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    logic [31:0]     rd;
    int              wt;
    logic [ADDR_W:0] a9;
    int              pend_kind, pend_age;
    logic [ADDR_W:0] pend_addr;
    logic [31:0]     pend_data;
    logic [63:0]     rnd;

    initial begin
        idle(3);
        @(negedge clk);
        chk("rst_MonDReg", MonDReg, 32'h0);
        chk("rst_flags", {29'b0, monitor_go, monitor_error, monitor_ready}, 32'h0);
        chk("rst_wait", 32'(cpu_waitrequest), 32'h0);
        chk("rst_readdata", cpu_readdata, 32'h0);
        step(); reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_MonDReg", MonDReg, 32'h0);

        // Enable monitor_go so CPU fills land in every build, then fill RAM.
        jtag(0, mk_a('0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < DEPTH; i++) begin
            a9 = '0;
            a9[ADDR_W-1:0] = i[ADDR_W-1:0];
            cpu_wr(a9, $urandom);
        end

        // JTAG writes at 0x10..0x12
        jtag(0, mk_a(8'h10, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            jtag(1, mk_b(32'hA5A5_0001 + 32'(k)));
            idle(2);
        end
        chk("model_addr_after_wr", 32'(m_addr), 32'h13);

        // JTAG reads back, each valid at pulse+3
        jtag(0, mk_a(8'h10, 1'b1, 1'b0, 1'b0));
        idle(3); @(negedge clk);
        chk("jtag_rd_0x10", MonDReg, 32'hA5A5_0001);
        chk("model_rd_0x10", m_dreg, 32'hA5A5_0001);
        for (int k = 1; k < 3; k++) begin
            jtag(2, '0);
            idle(3); @(negedge clk);
            chk("jtag_rd_next", MonDReg, 32'hA5A5_0001 + 32'(k));
        end

        // Address wrap
        cpu_wr('0, 32'h0BAD_F00D);
        jtag(0, mk_a(8'hFF, 1'b0, 1'b0, 1'b0)); idle(1);
        jtag(1, mk_b(32'h1234_5678)); idle(2);
        chk("model_addr_wrap", 32'(m_addr), 32'h0);
        jtag(2, '0); idle(3); @(negedge clk);
        chk("jtag_rd_wrap", MonDReg, 32'h0BAD_F00D);
        cpu_rd({1'b0, 8'hFF}, rd, wt);
        chk("cpu_rd_0xff", rd, 32'h1234_5678);
        chk("cpu_rd_waits", 32'(wt), 32'd1);

        // Flags through JTAG and the control register
        jtag(0, mk_a('0, 1'b0, 1'b1, 1'b1)); idle(1); @(negedge clk);
        chk("go_set", 32'(monitor_go), 32'd1);
        cpu_wr({1'b1, 8'h00}, 32'h5); idle(1); @(negedge clk);
        chk("ready_after_ctrl", 32'(monitor_ready), 32'd1);
        chk("go_after_ctrl", 32'(monitor_go), 32'd0);
        cpu_rd({1'b1, 8'h3C}, rd, wt);
        chk("ctrl_read", rd, 32'h1);
        chk("ctrl_read_waits", 32'(wt), 32'd0);

        // CPU read colliding with the JTAG ACCESS cycle (write lands at addr 0)
        jtag(1, mk_b(32'hCAFE_0000));
        cpu_rd({1'b0, 8'h11}, rd, wt);
        chk("collide_waits", 32'(wt), 32'd2);
        chk("collide_data", rd, 32'hA5A5_0002);

        // CPU RAM write with monitor_go low
        cpu_wr('0, 32'h0000_DEAD);
        cpu_rd('0, rd, wt);
`ifdef PARALLEL_HYPERVISOR_OCIMEM_WRITE_PROTECT_EN
        chk("wp_dropped", rd, 32'hCAFE_0000);
        jtag(0, mk_a(8'h00, 1'b0, 1'b0, 1'b1)); idle(1);
        cpu_wr('0, 32'h0000_DEAD);
        cpu_rd('0, rd, wt);
        chk("wp_landed", rd, 32'h0000_DEAD);
`else
        chk("wr_landed", rd, 32'h0000_DEAD);
`endif

        // Randomized traffic with held Avalon transactions
        pend_kind = 0; pend_age = 0; pend_addr = '0; pend_data = '0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (pend_kind == 0 && $urandom_range(0, 2) == 0) begin
                pend_kind = $urandom_range(1, 4);
                pend_age  = 0;
                rnd       = {$urandom, $urandom};
                pend_addr = rnd[ADDR_W:0];
                pend_addr[ADDR_W] = (pend_kind >= 3);
                pend_data = $urandom;
            end
            if (pend_kind != 0) begin
                cpu_address   = pend_addr;
                cpu_writedata = pend_data;
                cpu_read      = (pend_kind == 1) || (pend_kind == 3);
                cpu_write     = (pend_kind == 2) || (pend_kind == 4);
            end
            if ($urandom_range(0, 4) == 0) begin
                rnd = {$urandom, $urandom};
                jdo = rnd[37:0];
                take_action_ocimem_a    = ($urandom_range(0, 2) == 0);
                take_action_ocimem_b    = ($urandom_range(0, 2) == 0);
                take_no_action_ocimem_a = ($urandom_range(0, 1) == 0);
            end
            @(negedge clk);
            if (pend_kind != 0) begin
                if (!cpu_waitrequest) begin
                    pend_kind = 0;
                end else begin
                    pend_age++;
                    if (pend_age > 20) begin
                        tests++; fails++;
                        $display("FAIL rand_cpu_timeout: waitrequest held %0d cycles, required under 20", pend_age);
                        pend_kind = 0;
                    end
                end
            end
        end

        idle(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
